// File: rtl/pwm_duty_sequencer_if.sv
// Command channel of the PWM duty sequencer: a target-duty request with valid/ready handshake.
// A command transfers on any rising clk edge where cmd_valid and cmd_ready are both high.
interface pwm_duty_sequencer_if #(
    parameter int DW = 4
);
    logic          cmd_valid;
    logic [DW-1:0] cmd_duty;
    logic          cmd_ready;

    modport master (output cmd_valid, output cmd_duty, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_duty, output cmd_ready);
endinterface

// File: rtl/pwm_duty_sequencer.sv
// Ramps a PWM duty value toward commanded targets one step per STEP_PERIODS periods; buttons nudge it when idle.
// Optional soft start from duty 0 is enabled by defining PWM_DUTY_SEQUENCER_SOFTSTART_EN.
module pwm_duty_sequencer #(
    parameter int DW           = 4,
    parameter int MAX_DUTY     = 10,
    parameter int INIT_DUTY    = 5,
    parameter int STEP_PERIODS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       period_end,
    pwm_duty_sequencer_if.slave        cmd,
    input  logic                       btn_inc,
    input  logic                       btn_dec,
    output logic [DW-1:0]              duty,
    output logic                       busy,
    output logic                       done,
    output logic                       cmd_err,
    output logic [1:0]                 state_dbg
);
    localparam int            CW         = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(STEP_PERIODS - 1);
    localparam logic [DW-1:0] MAX_D      = DW'(MAX_DUTY);
    localparam logic [DW-1:0] INIT_D     = DW'(INIT_DUTY);

`ifdef PWM_DUTY_SEQUENCER_SOFTSTART_EN
    typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2, SOFT = 2'd3} state_t;
    localparam state_t        RST_STATE = SOFT;
    localparam logic [DW-1:0] RST_DUTY  = '0;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2} state_t;
    localparam state_t        RST_STATE = IDLE;
    localparam logic [DW-1:0] RST_DUTY  = INIT_D;
`endif

    state_t        state;
    logic [DW-1:0] target;
    logic [CW-1:0] dwell;
    logic          pend_inc;
    logic          pend_dec;
    logic          accept;
    logic [DW-1:0] cmd_clamped;
    logic [DW-1:0] next_duty;

    assign cmd.cmd_ready = (state == IDLE);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign cmd_clamped   = (cmd.cmd_duty > MAX_D) ? MAX_D : cmd.cmd_duty;
    assign busy          = (state != IDLE);
    assign state_dbg     = state;
    // Only DOWN ramps downward; UP and SOFT both climb toward target.
    assign next_duty     = (state == DOWN) ? duty - DW'(1) : duty + DW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RST_STATE;
            duty     <= RST_DUTY;
            target   <= INIT_D;
            dwell    <= '0;
            pend_inc <= 1'b0;
            pend_dec <= 1'b0;
            done     <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            done    <= 1'b0;
            cmd_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        // A command always wins over any pending or simultaneous button step.
                        target   <= cmd_clamped;
                        cmd_err  <= (cmd.cmd_duty > MAX_D);
                        pend_inc <= 1'b0;
                        pend_dec <= 1'b0;
                        dwell    <= '0;
                        if (cmd_clamped > duty)      state <= UP;
                        else if (cmd_clamped < duty) state <= DOWN;
                        else                         done  <= 1'b1;
                    end else begin
                        if (period_end) begin
                            if (pend_inc && duty != MAX_D)   duty <= duty + DW'(1);
                            else if (pend_dec && duty != '0) duty <= duty - DW'(1);
                            pend_inc <= 1'b0;
                            pend_dec <= 1'b0;
                        end
                        // A press in the wrap cycle is kept for the following period.
                        if (btn_inc && !btn_dec) begin
                            pend_inc <= 1'b1;
                            pend_dec <= 1'b0;
                        end else if (btn_dec && !btn_inc) begin
                            pend_inc <= 1'b0;
                            pend_dec <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (period_end) begin
                        if (dwell == DWELL_LAST) begin
                            dwell <= '0;
                            duty  <= next_duty;
                            if (next_duty == target) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end else begin
                            dwell <= dwell + CW'(1);
                        end
                    end
                end
            endcase
        end
    end
endmodule
